// File: rtl/reg_share_arbiter.sv
// Round-robin arbiter that time-shares one W-bit register among NREQ
// requesters. One requester is granted at a time. Each write by the grantee
// loads the register and raises a one-cycle ack. A hold limit forces the
// grant to rotate to another requester.
module reg_share_arbiter #(
  parameter int NREQ     = 4,
  parameter int W        = 4,
  parameter int MAX_HOLD = 8,
  parameter int CW       = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*W-1:0] data,
  output logic [NREQ-1:0]   gnt,
  output logic [NREQ-1:0]   ack,
  output logic [W-1:0]      reg_out,
  output logic [CW-1:0]     owner,
  output logic              busy
);

  localparam int HW = $clog2(MAX_HOLD) + 1;

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] GRANT = 1'b1;

  logic [0:0]    state;
  logic [CW-1:0] ptr;
  logic [HW-1:0] hold_cnt;

  logic          found;
  logic [CW-1:0] pick;
  logic [CW-1:0] next_ptr;
  logic          last_write;
  logic [W-1:0]  data_arr [NREQ];

  // Unpack the flat data bus into one word per requester
  always_comb begin
    for (int unsigned i = 0; i < NREQ; i++) begin
      data_arr[i] = data[i*W +: W];
    end
  end

  // Circular search for the first pending requester, starting at ptr
  always_comb begin
    int unsigned   idx;
    logic [CW-1:0] idx_c;
    found = 1'b0;
    pick  = '0;
    idx   = 0;
    idx_c = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      idx   = (32'(ptr) + k) % NREQ;
      idx_c = CW'(idx);
      if (!found && req[idx_c]) begin
        found = 1'b1;
        pick  = idx_c;
      end
    end
  end

  // Rotation pointer after a release, and the forced-release condition
  always_comb begin
    next_ptr   = (owner == CW'(NREQ - 1)) ? '0 : owner + CW'(1);
    last_write = (hold_cnt == HW'(MAX_HOLD - 1));
  end

  // Arbitration FSM, shared register and ack generation
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      ptr      <= '0;
      hold_cnt <= '0;
      gnt      <= '0;
      ack      <= '0;
      reg_out  <= '0;
      owner    <= '0;
      busy     <= 1'b0;
    end else if (state == IDLE) begin
      ack <= '0;
      if (found) begin
        gnt      <= NREQ'(1) << pick;
        owner    <= pick;
        busy     <= 1'b1;
        hold_cnt <= '0;
        state    <= GRANT;
      end else begin
        gnt <= '0;
      end
    end else begin
      if (req[owner]) begin
        reg_out  <= data_arr[owner];
        ack      <= NREQ'(1) << owner;
        hold_cnt <= hold_cnt + 1'b1;
      end else begin
        ack <= '0;
      end
      // Release on dropped request or on the final permitted write; the
      // hold_cnt clear below overrides the increment above.
      if (!req[owner] || last_write) begin
        gnt      <= '0;
        busy     <= 1'b0;
        state    <= IDLE;
        ptr      <= next_ptr;
        hold_cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_reg_share_arbiter.sv
// Directed testbench for reg_share_arbiter: one instance with MAX_HOLD=8
// and a second instance with MAX_HOLD=1, sharing clock and reset.
module tb_reg_share_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req,  req1;
  logic [15:0] data, data1;
  logic [3:0]  gnt,  ack,  reg_out;
  logic [3:0]  gnt1, ack1, reg_out1;
  logic [1:0]  owner, owner1;
  logic        busy,  busy1;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  reg_share_arbiter #(.NREQ(4), .W(4), .MAX_HOLD(8), .CW(2)) u_dut (
    .clk(clk), .rst(rst), .req(req), .data(data),
    .gnt(gnt), .ack(ack), .reg_out(reg_out), .owner(owner), .busy(busy)
  );

  reg_share_arbiter #(.NREQ(4), .W(4), .MAX_HOLD(1), .CW(2)) u_dut1 (
    .clk(clk), .rst(rst), .req(req1), .data(data1),
    .gnt(gnt1), .ack(ack1), .reg_out(reg_out1), .owner(owner1), .busy(busy1)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    req = '0; req1 = '0; data = '0; data1 = '0;
    tick();
    tick();
    tests++; if (gnt !== 4'b0000) begin fails++; $display("FAIL reset_gnt: got %b expected 0000", gnt); end
    tests++; if (owner !== 2'd0) begin fails++; $display("FAIL reset_owner: got %0d expected 0", owner); end
    rst = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick();
      tests++; if (gnt !== 4'b0000) begin fails++; $display("FAIL idle_gnt c%0d: got %b expected 0000", c, gnt); end
      tests++; if (ack !== 4'b0000) begin fails++; $display("FAIL idle_ack c%0d: got %b expected 0000", c, ack); end
      tests++; if (reg_out !== 4'h0) begin fails++; $display("FAIL idle_reg c%0d: got %h expected 0", c, reg_out); end
      tests++; if (busy !== 1'b0) begin fails++; $display("FAIL idle_busy c%0d: got %b expected 0", c, busy); end
    end
  endtask

  task automatic test_single();
    data = 16'hEEEA;            // data0=A, others must be ignored
    req  = 4'b0001;
    tick();
    tests++; if (gnt !== 4'b0001) begin fails++; $display("FAIL single_gnt: got %b expected 0001", gnt); end
    tests++; if (busy !== 1'b1) begin fails++; $display("FAIL single_busy: got %b expected 1", busy); end
    tests++; if (ack !== 4'b0000) begin fails++; $display("FAIL single_ack0: got %b expected 0000", ack); end
    for (int w = 0; w < 3; w++) begin
      tick();
      tests++; if (ack !== 4'b0001) begin fails++; $display("FAIL single_ack w%0d: got %b expected 0001", w, ack); end
      tests++; if (reg_out !== 4'hA) begin fails++; $display("FAIL single_reg w%0d: got %h expected a", w, reg_out); end
      tests++; if (gnt !== 4'b0001) begin fails++; $display("FAIL single_hold w%0d: got %b expected 0001", w, gnt); end
    end
    req = 4'b0000;
    tick();
    tests++; if (gnt !== 4'b0000) begin fails++; $display("FAIL single_rel_gnt: got %b expected 0000", gnt); end
    tests++; if (ack !== 4'b0000) begin fails++; $display("FAIL single_rel_ack: got %b expected 0000", ack); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL single_rel_busy: got %b expected 0", busy); end
    tests++; if (reg_out !== 4'hA) begin fails++; $display("FAIL single_rel_reg: got %h expected a", reg_out); end
    tests++; if (owner !== 2'd0) begin fails++; $display("FAIL single_rel_owner: got %0d expected 0", owner); end
  endtask

  task automatic test_rotation();
    logic [3:0] eg;
    int         g;
    do_reset();
    data = 16'h4321;
    req  = 4'b1111;
    for (int r = 0; r < 5; r++) begin
      g  = (r == 4) ? 0 : r;
      eg = 4'b0001 << g;
      tick();
      tests++; if (gnt !== eg) begin fails++; $display("FAIL rot_gnt r%0d: got %b expected %b", r, gnt, eg); end
      tests++; if (owner !== 2'(g)) begin fails++; $display("FAIL rot_owner r%0d: got %0d expected %0d", r, owner, g); end
      tests++; if (ack !== 4'b0000) begin fails++; $display("FAIL rot_ack0 r%0d: got %b expected 0000", r, ack); end
      for (int w = 0; w < 8; w++) begin
        tick();
        tests++; if (ack !== eg) begin fails++; $display("FAIL rot_ack r%0d w%0d: got %b expected %b", r, w, ack, eg); end
        tests++; if (reg_out !== 4'(g + 1)) begin fails++; $display("FAIL rot_reg r%0d w%0d: got %h expected %h", r, w, reg_out, 4'(g + 1)); end
        tests++; if (gnt !== ((w < 7) ? eg : 4'b0000)) begin fails++; $display("FAIL rot_hold r%0d w%0d: got %b expected %b", r, w, gnt, (w < 7) ? eg : 4'b0000); end
      end
    end
    req = 4'b0000;
    tick();
    tests++; if (ack !== 4'b0000) begin fails++; $display("FAIL rot_end_ack: got %b expected 0000", ack); end
  endtask

  task automatic test_wrap();
    do_reset();
    data = 16'h9005;            // data3=9, data0=5
    req  = 4'b0100;
    tick();
    tests++; if (gnt !== 4'b0100) begin fails++; $display("FAIL wrap_pre_gnt: got %b expected 0100", gnt); end
    req = 4'b0000;
    tick();
    tests++; if (gnt !== 4'b0000) begin fails++; $display("FAIL wrap_pre_rel: got %b expected 0000", gnt); end
    req = 4'b1001;
    tick();
    tests++; if (gnt !== 4'b1000) begin fails++; $display("FAIL wrap_first: got %b expected 1000", gnt); end
    tick();
    tests++; if (ack !== 4'b1000) begin fails++; $display("FAIL wrap_ack3: got %b expected 1000", ack); end
    tests++; if (reg_out !== 4'h9) begin fails++; $display("FAIL wrap_reg3: got %h expected 9", reg_out); end
    req = 4'b0001;
    tick();
    tests++; if (gnt !== 4'b0000) begin fails++; $display("FAIL wrap_rel: got %b expected 0000", gnt); end
    tick();
    tests++; if (gnt !== 4'b0001) begin fails++; $display("FAIL wrap_second: got %b expected 0001", gnt); end
    tick();
    tests++; if (reg_out !== 4'h5) begin fails++; $display("FAIL wrap_reg0: got %h expected 5", reg_out); end
    req = 4'b0000;
    tick();
    tick();
  endtask

  task automatic test_async_reset();
    data = 16'h0070;            // data1=7
    req  = 4'b0010;
    tick();
    tests++; if (gnt !== 4'b0010) begin fails++; $display("FAIL arst_pre_gnt: got %b expected 0010", gnt); end
    tick();
    tests++; if (reg_out !== 4'h7) begin fails++; $display("FAIL arst_pre_reg: got %h expected 7", reg_out); end
    #2;
    rst = 1'b0;
    #1;
    tests++; if (gnt !== 4'b0000) begin fails++; $display("FAIL arst_gnt: got %b expected 0000", gnt); end
    tests++; if (ack !== 4'b0000) begin fails++; $display("FAIL arst_ack: got %b expected 0000", ack); end
    tests++; if (reg_out !== 4'h0) begin fails++; $display("FAIL arst_reg: got %h expected 0", reg_out); end
    tests++; if (owner !== 2'd0) begin fails++; $display("FAIL arst_owner: got %0d expected 0", owner); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL arst_busy: got %b expected 0", busy); end
    req = 4'b0011;
    rst = 1'b1;
    tick();
    tests++; if (gnt !== 4'b0001) begin fails++; $display("FAIL arst_next_gnt: got %b expected 0001", gnt); end
    req = 4'b0000;
    tick();
    tick();
  endtask

  task automatic test_max_hold_one();
    logic [3:0] eg;
    int         g;
    data1 = 16'h0063;           // data0=3, data1=6
    req1  = 4'b0011;
    for (int r = 0; r < 4; r++) begin
      g  = r % 2;
      eg = 4'b0001 << g;
      tick();
      tests++; if (gnt1 !== eg) begin fails++; $display("FAIL mh1_gnt r%0d: got %b expected %b", r, gnt1, eg); end
      tests++; if (ack1 !== 4'b0000) begin fails++; $display("FAIL mh1_ack0 r%0d: got %b expected 0000", r, ack1); end
      tick();
      tests++; if (ack1 !== eg) begin fails++; $display("FAIL mh1_ack r%0d: got %b expected %b", r, ack1, eg); end
      tests++; if (gnt1 !== 4'b0000) begin fails++; $display("FAIL mh1_rel r%0d: got %b expected 0000", r, gnt1); end
      tests++; if (reg_out1 !== ((g == 0) ? 4'h3 : 4'h6)) begin fails++; $display("FAIL mh1_reg r%0d: got %h expected %h", r, reg_out1, (g == 0) ? 4'h3 : 4'h6); end
    end
    req1 = 4'b0000;
    tick();
  endtask

  initial begin
    test_reset();
    test_single();
    test_rotation();
    test_wrap();
    test_async_reset();
    test_max_hold_one();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
